// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: 8x8 multiply sequenced over four shared 4x4 sub-products with saturation.
module mult_8x8_seq_ctrl #(
  parameter int CFG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [CFG_W-1:0] cfg,
  output logic [3:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_sel,
  input  logic [7:0]       sub_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      R,
  output logic             ovf
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [16:0]      acc_q, acc_d, sum;
  logic [15:0]      r_q, r_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       sh;
  // 17-bit accumulator: the approximate sub-products can push the total past 16 bits
  assign sh = state_q == MUL3 ? 4'd8 : state_q == MUL0 ? 4'd0 : 4'd4;
  assign sum = acc_q + ({9'd0, sub_r} << sh);
  assign in_ready = ~rst & (state_q == IDLE);
  assign out_valid = state_q == DONE;
  assign R = r_q;
  assign ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cfg_d = cfg_q;
    acc_d = acc_q;
    r_d = r_q;
    ovf_d = ovf_q;
    sub_a = 4'd0;
    sub_b = 4'd0;
    sub_sel = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = MUL0;
        a_d = A;
        b_d = B;
        cfg_d = cfg;
        acc_d = '0;
      end
      MUL0: begin
        sub_a = a_q[3:0];
        sub_b = b_q[3:0];
        sub_sel = cfg_q[0];
        acc_d = sum;
        state_d = MUL1;
      end
      MUL1: begin
        sub_a = a_q[3:0];
        sub_b = b_q[7:4];
        sub_sel = cfg_q[1];
        acc_d = sum;
        state_d = MUL2;
      end
      MUL2: begin
        sub_a = a_q[7:4];
        sub_b = b_q[3:0];
        sub_sel = cfg_q[2];
        acc_d = sum;
        state_d = MUL3;
      end
      MUL3: begin
        sub_a = a_q[7:4];
        sub_b = b_q[7:4];
        sub_sel = cfg_q[3];
        acc_d = sum;
        r_d = sum[16] ? 16'hFFFF : sum[15:0];
        ovf_d = sum[16];
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cfg_q <= '0;
      acc_q <= '0;
      r_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cfg_q <= cfg_d;
      acc_q <= acc_d;
      r_q <= r_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb_mult_8x8_seq_ctrl: random and directed transactions checked against a product-level reference.
module tb_mult_8x8_seq_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, sub_sel, out_valid, ovf;
  logic [7:0] A = 0, B = 0, sub_r;
  logic [3:0] cfg = 0, sub_a, sub_b;
  logic [15:0] R;
  bit force_ff = 0;
  int n_cmp = 0, n_bad = 0;

  mult_8x8_seq_ctrl #(.CFG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cfg(cfg), .sub_a(sub_a), .sub_b(sub_b), .sub_sel(sub_sel),
    .sub_r(sub_r), .out_valid(out_valid), .out_ready(out_ready), .R(R), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sm(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] p;
    p = {4'd0, a} * {4'd0, b};
    return s ? (p | 8'h11) : p;
  endfunction

  always_comb sub_r = force_ff ? 8'hFF : sm(sub_a, sub_b, sub_sel);

  function automatic int ref_acc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input bit ff);
    if (ff) return 255 * (1 + 16 + 16 + 256);
    if (c == 4'd0) return int'(a) * int'(b);
    return int'(sm(a[3:0], b[3:0], c[0])) + (int'(sm(a[3:0], b[7:4], c[1])) << 4)
         + (int'(sm(a[7:4], b[3:0], c[2])) << 4) + (int'(sm(a[7:4], b[7:4], c[3])) << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input int hold, input bit scr);
    int e;
    logic [15:0] er;
    logic [3:0] na [4];
    logic [3:0] nb [4];
    e = ref_acc(a, b, c, force_ff);
    er = e > 65535 ? 16'hFFFF : 16'(e);
    na = '{a[3:0], a[3:0], a[7:4], a[7:4]};
    nb = '{b[3:0], b[7:4], b[3:0], b[7:4]};
    @(negedge clk);
    A = a; B = b; cfg = c; in_valid = 1; out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = scr;
    for (int k = 0; k < 4; k++) begin
      chk("sub_a", sub_a, na[k]);
      chk("sub_b", sub_b, nb[k]);
      chk("sub_sel", sub_sel, c[k]);
      chk("busy_in_ready", in_ready, 0);
      chk("early_out_valid", out_valid, 0);
      if (scr) begin A = 8'($urandom); B = 8'($urandom); cfg = 4'($urandom); end
      @(negedge clk);
    end
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid", out_valid, 1);
      chk("R", R, er);
      chk("ovf", ovf, e > 65535);
      chk("done_in_ready", in_ready, 0);
      chk("done_sub_zero", {sub_a, sub_b, sub_sel}, 0);
      if (i == hold) out_ready = 1;
      in_valid = 1;
      @(negedge clk);
    end
    chk("exit_out_valid", out_valid, 0);
    chk("exit_in_ready", in_ready, 1);
    in_valid = 0; out_ready = 0;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_R", R, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sub", {sub_a, sub_b, sub_sel}, 0);
    @(negedge clk);
    rst = 0;
    txn(8'hFF, 8'hFF, 4'h0, 0, 0);
    chk("ff_ff_product", R, 16'hFE01);
    txn(8'h00, 8'hA5, 4'($urandom), 2, 0);
    txn(8'h12, 8'h34, 4'h0, 10, 0);
    chk("h12_h34_product", R, 16'h03A8);
    force_ff = 1;
    txn(8'($urandom), 8'($urandom), 4'h0, 1, 0);
    chk("forced_ff_sat", {ovf, R}, 17'h1FFFF);
    force_ff = 0;
    txn(8'h5A, 8'hC3, 4'b1010, 0, 1);
    txn(8'h9C, 8'h7B, 4'b0110, 3, 1);
    @(negedge clk);
    A = 8'h77; B = 8'h99; cfg = 4'hF; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_R", R, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_sub", {sub_a, sub_b, sub_sel}, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      chk("abandoned_no_valid", out_valid, 0);
      @(negedge clk);
    end
    txn(8'd3, 8'd5, 4'h0, 0, 0);
    chk("after_rst_product", R, 16'd15);
    for (int n = 0; n < 40; n++)
      txn(8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
